stdp_update_sched: RTL and testbench

Update scheduler for the 4-input STDP synapse group. Tracks pre/post spike timing per synapse, queues one potentiation (LTP) or depression (LTD) request per synapse, and uses round-robin arbitration to grant those requests to a single shared saturating weight-update datapath. Each updated weight is held in a local register file and is also presented to the downstream weight store through a valid/ready handshake.

---
 rtl/stdp_update_sched.sv | 251 +++++++++++++++++++++++++
 tb/tb_stdp_update_sched.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_update_sched.sv
// stdp_update_sched: per-synapse STDP timing capture, round-robin arbitration of
// LTP/LTD requests onto one shared saturating weight-update datapath, with the
// updated weight offered downstream over a valid/ready handshake.
module stdp_update_sched #(
  parameter int unsigned NUM_PRE = 4,
  parameter int unsigned TW      = 4,
  parameter int unsigned WW      = 4,
  parameter int unsigned WINDOW  = 8,
  parameter int unsigned INIT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic                       post_spike,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [$clog2(NUM_PRE)-1:0] upd_idx,
  output logic                       upd_ltp,
  output logic [WW-1:0]              upd_weight,
  output logic [NUM_PRE*WW-1:0]      weight,
  output logic                       busy,
  output logic                       ovf
);

  localparam int unsigned   IW       = $clog2(NUM_PRE);
  localparam logic [TW-1:0] T_SAT    = {TW{1'b1}};
  localparam logic [TW:0]   WIN      = (TW+1)'(WINDOW);
  localparam logic [WW-1:0] W_MAX    = {WW{1'b1}};
  localparam logic [WW-1:0] W_INIT   = WW'(INIT_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PRE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    OFFER = 2'd2
  } state_t;

  state_t state, state_n;

  // spike timers
  logic [TW-1:0] pre_timer [NUM_PRE];
  logic [TW-1:0] post_timer;

  // request capture
  logic [NUM_PRE-1:0] ltp_set, ltd_set;
  logic [TW-1:0]      ltp_new_dt [NUM_PRE];
  logic               post_in_win;

  // pending requests and their latched dt
  logic [NUM_PRE-1:0] ltp_pend, ltd_pend;
  logic [NUM_PRE-1:0] ltp_pend_n, ltd_pend_n;
  logic [NUM_PRE-1:0] ltp_clr, ltd_clr;
  logic [TW-1:0]      ltp_dt [NUM_PRE];
  logic [TW-1:0]      ltd_dt [NUM_PRE];
  logic               ovf_hit;

  // arbitration
  logic [NUM_PRE-1:0] cand;
  logic               any_cand;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      probe;
  logic               found;
  logic [IW-1:0]      sel_idx;
  logic               sel_ltp;
  logic [TW-1:0]      sel_dt;

  // FSM controls
  logic grant, load_upd, accept;

  // granted request
  logic [IW-1:0] g_idx;
  logic          g_ltp;
  logic [TW-1:0] g_dt;

  // update datapath
  logic [TW:0]   delta;
  logic [WW-1:0] w_cur;
  logic [WW:0]   w_sum, w_dif;
  logic [WW-1:0] w_add, w_sub, w_new;
  logic [WW-1:0] w_q [NUM_PRE];

  // Timers reset saturated so nothing looks recent after reset; a spike restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRE; i++) pre_timer[i] <= T_SAT;
      post_timer <= T_SAT;
    end else begin
      for (int i = 0; i < NUM_PRE; i++) begin
        if (pre_spike[i])              pre_timer[i] <= '0;
        else if (pre_timer[i] != T_SAT) pre_timer[i] <= pre_timer[i] + TW'(1);
      end
      if (post_spike)              post_timer <= '0;
      else if (post_timer != T_SAT) post_timer <= post_timer + TW'(1);
    end
  end

  // New LTP/LTD requests from this cycle's spikes against the pre-update timers.
  always_comb begin
    post_in_win = ({1'b0, post_timer} < WIN);
    ltp_set     = '0;
    ltd_set     = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      ltp_set[i]    = post_spike & (pre_spike[i] | ({1'b0, pre_timer[i]} < WIN));
      ltp_new_dt[i] = pre_spike[i] ? '0 : pre_timer[i];
      ltd_set[i]    = pre_spike[i] & ~post_spike & post_in_win;
    end
  end

  // Round-robin search starting at rr_ptr; LTP wins over LTD inside a synapse.
  always_comb begin
    cand     = ltp_pend | ltd_pend;
    any_cand = |cand;
    found    = 1'b0;
    sel_idx  = '0;
    probe    = '0;
    for (int k = 0; k < NUM_PRE; k++) begin
      probe = IW'((int'(rr_ptr) + k) % NUM_PRE);
      if (!found && cand[probe]) begin
        found   = 1'b1;
        sel_idx = probe;
      end
    end
    sel_ltp = ltp_pend[sel_idx];
    sel_dt  = sel_ltp ? ltp_dt[sel_idx] : ltd_dt[sel_idx];
  end

  // Pending next-state: a grant clears its bit, a same-cycle set overrides the clear.
  always_comb begin
    ltp_clr = '0;
    ltd_clr = '0;
    if (grant) begin
      if (sel_ltp) ltp_clr[sel_idx] = 1'b1;
      else         ltd_clr[sel_idx] = 1'b1;
    end
    ltp_pend_n = ltp_set | (ltp_pend & ~ltp_clr);
    ltd_pend_n = ltd_set | (ltd_pend & ~ltd_clr);
    ovf_hit    = (|(ltp_set & ltp_pend & ~ltp_clr)) | (|(ltd_set & ltd_pend & ~ltd_clr));
  end

  // Pending bits, latched dt values and the sticky overwrite flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ltp_pend <= '0;
      ltd_pend <= '0;
      ovf      <= 1'b0;
      for (int i = 0; i < NUM_PRE; i++) begin
        ltp_dt[i] <= '0;
        ltd_dt[i] <= '0;
      end
    end else begin
      ltp_pend <= ltp_pend_n;
      ltd_pend <= ltd_pend_n;
      if (ovf_hit) ovf <= 1'b1;
      for (int i = 0; i < NUM_PRE; i++) begin
        if (ltp_set[i]) ltp_dt[i] <= ltp_new_dt[i];
        if (ltd_set[i]) ltd_dt[i] <= post_timer;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state: grant in IDLE, compute in CALC, hold the offer until accepted.
  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    load_upd = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (en && any_cand) begin
          grant   = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        load_upd = 1'b1;
        state_n  = OFFER;
      end
      OFFER: begin
        if (upd_ready) begin
          accept  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Latch the granted request and advance the round-robin pointer past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_idx  <= '0;
      g_ltp  <= 1'b0;
      g_dt   <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      g_idx  <= sel_idx;
      g_ltp  <= sel_ltp;
      g_dt   <= sel_dt;
      rr_ptr <= (sel_idx == IDX_LAST) ? '0 : sel_idx + IW'(1);
    end
  end

  // Saturating add/sub of the window delta, one bit wider than the weight.
  always_comb begin
    delta = WIN - {1'b0, g_dt};
    w_cur = w_q[g_idx];
    w_sum = {1'b0, w_cur} + (WW+1)'(delta);
    w_dif = {1'b0, w_cur} - (WW+1)'(delta);
    w_add = w_sum[WW] ? W_MAX : w_sum[WW-1:0];
    w_sub = w_dif[WW] ? '0 : w_dif[WW-1:0];
    w_new = g_ltp ? w_add : w_sub;
  end

  // Weight file and downstream offer; both change only on the edge leaving CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRE; i++) w_q[i] <= W_INIT;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      upd_ltp    <= 1'b0;
      upd_weight <= '0;
    end else if (load_upd) begin
      w_q[g_idx] <= w_new;
      upd_valid  <= 1'b1;
      upd_idx    <= g_idx;
      upd_ltp    <= g_ltp;
      upd_weight <= w_new;
    end else if (accept) begin
      upd_valid <= 1'b0;
    end
  end

  // Busy mirrors the post-edge FSM state and pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= (state_n != IDLE) | (|ltp_pend_n) | (|ltd_pend_n);
  end

  // Pack the weight file onto the bus, synapse 0 in the MSBs.
  for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_pack
    assign weight[(NUM_PRE-1-gi)*WW +: WW] = w_q[gi];
  end

endmodule

// File: tb/tb_stdp_update_sched.sv
// tb_stdp_update_sched: directed vector table, hand-written corner sequences and
// randomized stimulus against a behavioural STDP scheduler model.
module tb_stdp_update_sched;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  pre_spike;
  logic        post_spike;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_idx;
  logic        upd_ltp;
  logic [3:0]  upd_weight;
  logic [15:0] weight;
  logic        busy;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  stdp_update_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_idx    (upd_idx),
    .upd_ltp    (upd_ltp),
    .upd_weight (upd_weight),
    .weight     (weight),
    .busy       (busy),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the summary line");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: inputs are applied at the falling edge and sampled at the next rising edge.
  task automatic step(input logic [3:0] pre, input logic post);
    @(negedge clk);
    pre_spike  = pre;
    post_spike = post;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    pre_spike  = '0;
    post_spike = 1'b0;
    en         = 1'b1;
    upd_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max_cyc && !ok; k++) begin
      step(4'b0000, 1'b0);
      if (upd_valid) ok = 1'b1;
    end
    check({name, "_wait_valid"}, 32'(ok), 32'd1);
  endtask

  // pre spike on the masked synapses, post spike gap cycles later
  task automatic causal(input logic [3:0] mask, input int gap);
    step(mask, 1'b0);
    for (int k = 1; k < gap; k++) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
  endtask

  // post spike, then pre spike on the masked synapses gap cycles later
  task automatic anticausal(input logic [3:0] mask, input int gap);
    step(4'b0000, 1'b1);
    for (int k = 1; k < gap; k++) step(4'b0000, 1'b0);
    step(mask, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'b0000, 1'b0);
  endtask

  // ---------------- behavioural reference model ----------------
  int m_pre_t [4];
  int m_post_t;
  bit m_ltp_p [4];
  bit m_ltd_p [4];
  int m_ltp_d [4];
  int m_ltd_d [4];
  int m_w     [4];
  int m_rr;
  bit m_ovf;
  int m_age;     // -1: no transaction, 0: computing, 1: offered
  int m_idx;
  bit m_fltp;
  int m_neww;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pre_t[i] = 15;
      m_ltp_p[i] = 1'b0;
      m_ltd_p[i] = 1'b0;
      m_ltp_d[i] = 0;
      m_ltd_d[i] = 0;
      m_w[i]     = 8;
    end
    m_post_t = 15;
    m_rr     = 0;
    m_ovf    = 1'b0;
    m_age    = -1;
    m_idx    = 0;
    m_fltp   = 1'b0;
    m_neww   = 0;
  endtask

  function automatic int clamp_w(input int v);
    if (v < 0)  return 0;
    if (v > 15) return 15;
    return v;
  endfunction

  function automatic bit model_any_pend();
    bit any;
    any = 1'b0;
    for (int i = 0; i < 4; i++) any = any | m_ltp_p[i] | m_ltd_p[i];
    return any;
  endfunction

  task automatic model_step(input logic [3:0] pre, input logic post, input logic en_i, input logic rdy);
    int  dt;
    int  j;
    bit  found;
    if (m_age == 1) begin
      if (rdy) m_age = -1;
    end else if (m_age == 0) begin
      m_w[m_idx] = m_neww;
      m_age      = 1;
    end else if (en_i && model_any_pend()) begin
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && (m_ltp_p[(m_rr + k) % 4] || m_ltd_p[(m_rr + k) % 4])) begin
          found = 1'b1;
          j     = (m_rr + k) % 4;
        end
      end
      m_idx  = j;
      m_fltp = m_ltp_p[j];
      if (m_fltp) begin
        dt         = m_ltp_d[j];
        m_ltp_p[j] = 1'b0;
        m_neww     = clamp_w(m_w[j] + (8 - dt));
      end else begin
        dt         = m_ltd_d[j];
        m_ltd_p[j] = 1'b0;
        m_neww     = clamp_w(m_w[j] - (8 - dt));
      end
      m_rr  = (j + 1) % 4;
      m_age = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (post && (pre[i] || m_pre_t[i] < 8)) begin
        if (m_ltp_p[i]) m_ovf = 1'b1;
        m_ltp_p[i] = 1'b1;
        m_ltp_d[i] = pre[i] ? 0 : m_pre_t[i];
      end
      if (pre[i] && !post && m_post_t < 8) begin
        if (m_ltd_p[i]) m_ovf = 1'b1;
        m_ltd_p[i] = 1'b1;
        m_ltd_d[i] = m_post_t;
      end
    end
    for (int i = 0; i < 4; i++) m_pre_t[i] = pre[i] ? 0 : ((m_pre_t[i] < 15) ? m_pre_t[i] + 1 : 15);
    m_post_t = post ? 0 : ((m_post_t < 15) ? m_post_t + 1 : 15);
  endtask

  task automatic model_compare(input int c);
    int bus;
    bus = (m_w[0] << 12) | (m_w[1] << 8) | (m_w[2] << 4) | m_w[3];
    check($sformatf("rnd%0d_valid", c), 32'(upd_valid), 32'(m_age == 1));
    if (m_age == 1) begin
      check($sformatf("rnd%0d_idx", c), 32'(upd_idx), 32'(m_idx));
      check($sformatf("rnd%0d_ltp", c), 32'(upd_ltp), 32'(m_fltp));
      check($sformatf("rnd%0d_upd_weight", c), 32'(upd_weight), 32'(m_neww));
    end
    check($sformatf("rnd%0d_weight", c), 32'(weight), 32'(bus));
    check($sformatf("rnd%0d_ovf", c), 32'(ovf), 32'(m_ovf));
    check($sformatf("rnd%0d_busy", c), 32'(busy), 32'((m_age != -1) || model_any_pend()));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          pre_cyc;
    logic [3:0]  pre_mask;
    int          post_cyc;
    int          exp_cyc;   // -1: no update expected
    logic [1:0]  exp_idx;
    logic        exp_ltp;
    logic [3:0]  exp_w;
    logic [15:0] exp_bus;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int seen;
    int cnt;
    int gap;

    vecs[0] = '{0, 4'b0010, 3, 6,  2'd1, 1'b1, 4'd14, 16'h8E88}; // causal dt=2
    vecs[1] = '{0, 4'b0001, 0, 3,  2'd0, 1'b1, 4'd15, 16'hF888}; // coincident dt=0
    vecs[2] = '{2, 4'b0100, 0, 5,  2'd2, 1'b0, 4'd1,  16'h8818}; // anticausal dt=1
    vecs[3] = '{8, 4'b1000, 0, 11, 2'd3, 1'b0, 4'd7,  16'h8887}; // LTD dt=7, window edge
    vecs[4] = '{9, 4'b1000, 0, -1, 2'd0, 1'b0, 4'd0,  16'h8888}; // LTD dt=8, outside
    vecs[5] = '{0, 4'b0001, 8, 11, 2'd0, 1'b1, 4'd9,  16'h9888}; // LTP dt=7, window edge
    vecs[6] = '{0, 4'b0100, 9, -1, 2'd0, 1'b0, 4'd0,  16'h8888}; // LTP dt=8, outside

    rst_n      = 1'b0;
    en         = 1'b1;
    upd_ready  = 1'b1;
    pre_spike  = '0;
    post_spike = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid",  32'(upd_valid),  32'd0);
    check("reset_weight", 32'(weight),     32'h8888);
    check("reset_busy",   32'(busy),       32'd0);
    check("reset_ovf",    32'(ovf),        32'd0);
    check("reset_idx",    32'(upd_idx),    32'd0);
    check("reset_upd_w",  32'(upd_weight), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      seen = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
        step((cyc == vecs[v].pre_cyc) ? vecs[v].pre_mask : 4'b0000, cyc == vecs[v].post_cyc);
        if (upd_valid) seen++;
        if (vecs[v].exp_cyc >= 0 && cyc == vecs[v].exp_cyc - 1)
          check($sformatf("vec%0d_early_valid", v), 32'(upd_valid), 32'd0);
        if (cyc == vecs[v].exp_cyc) begin
          check($sformatf("vec%0d_valid", v),  32'(upd_valid),  32'd1);
          check($sformatf("vec%0d_idx", v),    32'(upd_idx),    32'(vecs[v].exp_idx));
          check($sformatf("vec%0d_ltp", v),    32'(upd_ltp),    32'(vecs[v].exp_ltp));
          check($sformatf("vec%0d_upd_w", v),  32'(upd_weight), 32'(vecs[v].exp_w));
          check($sformatf("vec%0d_weight", v), 32'(weight),     32'(vecs[v].exp_bus));
        end
      end
      check($sformatf("vec%0d_update_count", v), 32'(seen), (vecs[v].exp_cyc >= 0) ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_final_weight", v), 32'(weight), 32'(vecs[v].exp_bus));
      check($sformatf("vec%0d_final_busy", v), 32'(busy), 32'd0);
    end

    // Saturation: two causal LTPs then two anticausal LTDs
    do_reset();
    causal(4'b0010, 3);
    wait_valid(10, "sat_ltp1");
    check("sat_ltp1_w", 32'(upd_weight), 32'd14);
    idle(16);
    causal(4'b0010, 3);
    wait_valid(10, "sat_ltp2");
    check("sat_ltp2_w",   32'(upd_weight), 32'd15);
    check("sat_ltp2_bus", 32'(weight),     32'h8F88);
    idle(16);
    anticausal(4'b0100, 2);
    wait_valid(10, "sat_ltd1");
    check("sat_ltd1_idx", 32'(upd_idx),    32'd2);
    check("sat_ltd1_ltp", 32'(upd_ltp),    32'd0);
    check("sat_ltd1_w",   32'(upd_weight), 32'd1);
    check("sat_ltd1_bus", 32'(weight),     32'h8F18);
    idle(16);
    anticausal(4'b0100, 2);
    wait_valid(10, "sat_ltd2");
    check("sat_ltd2_w",   32'(upd_weight), 32'd0);
    check("sat_ltd2_bus", 32'(weight),     32'h8F08);

    // Round-robin under back-pressure
    do_reset();
    upd_ready = 1'b0;
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b1);
    wait_valid(10, "rr_first");
    check("rr_first_idx", 32'(upd_idx),    32'd0);
    check("rr_first_ltp", 32'(upd_ltp),    32'd1);
    check("rr_first_w",   32'(upd_weight), 32'd15);
    for (int k = 2; k <= 5; k++) begin
      step(4'b0000, 1'b0);
      check($sformatf("rr_hold%0d_valid", k), 32'(upd_valid),  32'd1);
      check($sformatf("rr_hold%0d_idx", k),   32'(upd_idx),    32'd0);
      check($sformatf("rr_hold%0d_ltp", k),   32'(upd_ltp),    32'd1);
      check($sformatf("rr_hold%0d_w", k),     32'(upd_weight), 32'd15);
      check($sformatf("rr_hold%0d_bus", k),   32'(weight),     32'hF888);
    end
    step(4'b0000, 1'b0);
    check("rr_hold6_valid", 32'(upd_valid), 32'd1);
    upd_ready = 1'b1;
    for (int g = 1; g <= 3; g++) begin
      gap  = 0;
      seen = 0;
      while (seen == 0 && gap < 10) begin
        step(4'b0000, 1'b0);
        gap++;
        if (upd_valid) seen = 1;
      end
      check($sformatf("rr_grant%0d_spacing", g), 32'(gap),        32'd3);
      check($sformatf("rr_grant%0d_idx", g),     32'(upd_idx),    32'(g));
      check($sformatf("rr_grant%0d_w", g),       32'(upd_weight), 32'd15);
    end
    idle(4);
    check("rr_final_bus",  32'(weight), 32'hFFFF);
    check("rr_final_busy", 32'(busy),   32'd0);

    // Overwrite with grants disabled, then a single update using the newer dt
    do_reset();
    en = 1'b0;
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step(4'b0000, 1'b0);
      if (upd_valid) seen++;
    end
    check("ovw_no_valid", 32'(seen), 32'd0);
    check("ovw_ovf",      32'(ovf),  32'd1);
    check("ovw_busy",     32'(busy), 32'd1);
    en = 1'b1;
    wait_valid(10, "ovw_grant");
    check("ovw_idx", 32'(upd_idx),    32'd3);
    check("ovw_ltp", 32'(upd_ltp),    32'd1);
    check("ovw_w",   32'(upd_weight), 32'd14);
    check("ovw_bus", 32'(weight),     32'h888E);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(4'b0000, 1'b0);
      if (upd_valid) cnt++;
    end
    check("ovw_single_update", 32'(cnt),  32'd0);
    check("ovw_idle_busy",     32'(busy), 32'd0);
    check("ovw_ovf_sticky",    32'(ovf),  32'd1);

    // Asynchronous reset while an update is being offered
    upd_ready = 1'b0;
    causal(4'b0010, 3);
    wait_valid(10, "rst_offer");
    check("rst_offer_bus", 32'(weight), 32'h8E8E);
    step(4'b0000, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(upd_valid),  32'd0);
    check("rst_async_bus",   32'(weight),     32'h8888);
    check("rst_async_ovf",   32'(ovf),        32'd0);
    check("rst_async_busy",  32'(busy),       32'd0);
    check("rst_async_idx",   32'(upd_idx),    32'd0);
    check("rst_async_ltp",   32'(upd_ltp),    32'd0);
    check("rst_async_upd_w", 32'(upd_weight), 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    upd_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b0000, 1'b0);
      if (upd_valid) cnt++;
    end
    check("rst_quiet_valid", 32'(cnt),  32'd0);
    check("rst_quiet_busy",  32'(busy), 32'd0);

    // Randomized stimulus against the reference model
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      model_reset();
      for (int c = 0; c < 700; c++) begin
        @(negedge clk);
        model_compare(blk * 1000 + c);
        for (int i = 0; i < 4; i++) pre_spike[i] = ($urandom_range(0, 7 + 4 * blk) == 0);
        post_spike = ($urandom_range(0, 5 + 3 * blk) == 0);
        en         = ($urandom_range(0, 9) != 0);
        upd_ready  = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        model_step(pre_spike, post_spike, en, upd_ready);
      end
      @(negedge clk);
      pre_spike  = '0;
      post_spike = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
